// File: rtl/gemm_reader_pkg.sv
// Shared types and helpers for the GeMM result reader.
// Holds the FSM state enum, packing constants and beat-count helper.
package gemm_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int ELEMS_PER_BEAT = 4;
  localparam int URAM_IDX_W     = 6;
  localparam int CFG_W          = 15;
  localparam int BEAT_W         = CFG_W + URAM_IDX_W - 2;

  // 64 elements per address, 4 elements per beat -> 16 beats per address
  function automatic logic [BEAT_W-1:0] beat_count(
    input logic [CFG_W-1:0] num_addr
  );
    return {num_addr, {(URAM_IDX_W - 2){1'b0}}};
  endfunction

endpackage

// File: rtl/result_elem_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk, reset, wr_en/wr_data, rd_en/rd_data, count, full.
module result_elem_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign rd_data = mem[rptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && (cnt_q != '0);

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wptr_q <= nxt(wptr_q);
      if (rd_ok) rptr_q <= nxt(rptr_q);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (reset || !(wr_en && full))
      else $error("result_elem_fifo: write into full FIFO");
  end
`endif

endmodule

// File: rtl/op_uram_result_reader.sv
// Drains the GeMM output URAMs via port B and packs 16-bit results
// into 64-bit valid/ready beats. Ports: clk, reset, start,
// cfg_num_addr, busy, done, op_uram_addrb/enb/doutb_valid/doutb,
// m_tdata/m_tvalid/m_tlast/m_tready. RESULT_READER_CHECKSUM_EN
// adds checksum/checksum_valid.
module op_uram_result_reader
  import gemm_reader_pkg::*;
#(
  parameter int NUM_URAM   = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 64,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_num_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] op_uram_addrb,
  output logic [NUM_URAM-1:0]   op_uram_enb,
  output logic [NUM_URAM-1:0]   op_uram_doutb_valid,
  input  logic [DATA_WIDTH-1:0] op_uram_doutb,
  output logic [OUT_WIDTH-1:0]  m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
`ifdef RESULT_READER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum,
  output logic                  checksum_valid
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = BEAT_W;
  localparam int LW = $clog2(ELEMS_PER_BEAT);

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH:0]     num_q;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic [URAM_IDX_W-1:0]   u_q;
  logic [RD_LAT-1:0]       pipe_q;
  logic [NUM_URAM-1:0]     dv_q [RD_LAT-1];
  logic [CW-1:0]           fifo_cnt;
  logic [DATA_WIDTH-1:0]   fifo_dout;
  logic                    fifo_full;
  logic [CW:0]             used;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_rd;
  logic                    accept;
  logic                    pull;
  logic                    hs;
  logic [BW-1:0]           beats_q;
  logic [BW-1:0]           fill_q;
  logic [LW-1:0]           lane_q;
  logic [OUT_WIDTH-1:0]    data_q;
  logic                    valid_q;
  logic                    last_q;

  assign accept = (state_q == IDLE) && start;
  assign hs     = valid_q && m_tready;

  // Credit counts every read still in the URAM pipe as FIFO space
  assign used      = {1'b0, fifo_cnt} + (CW + 1)'($countones(pipe_q));
  assign credit_ok = used < (CW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == READ) && credit_ok;
  assign last_rd   = (u_q == '1) && ({1'b0, a_q} == num_q - 1'b1);

  assign op_uram_enb   = issue ? ({{(NUM_URAM - 1){1'b0}}, 1'b1} << u_q) : '0;
  assign op_uram_addrb = issue ? a_q : '0;
  assign op_uram_doutb_valid = dv_q[RD_LAT-2];

  assign busy = (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (cfg_num_addr == '0) ? DONE : READ;
      READ:  if (issue && last_rd) state_d = DRAIN;
      DRAIN: if (hs && last_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q   <= '0;
      a_q     <= '0;
      u_q     <= '0;
      beats_q <= '0;
    end else if (accept) begin
      num_q   <= cfg_num_addr;
      a_q     <= '0;
      u_q     <= '0;
      beats_q <= beat_count(cfg_num_addr);
    end else if (issue) begin
      u_q <= u_q + 1'b1;
      if (u_q == '1) a_q <= a_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
      for (int i = 0; i < RD_LAT - 1; i++) dv_q[i] <= '0;
    end else begin
      pipe_q  <= {pipe_q[RD_LAT-2:0], issue};
      dv_q[0] <= op_uram_enb;
      for (int i = 1; i < RD_LAT - 1; i++) dv_q[i] <= dv_q[i-1];
    end
  end

  result_elem_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pipe_q[RD_LAT-1]),
    .wr_data (op_uram_doutb),
    .rd_en   (pull),
    .rd_data (fifo_dout),
    .count   (fifo_cnt),
    .full    (fifo_full)
  );

  // A held beat blocks refill; a beat leaving this cycle frees lane 0
  assign pull = (fifo_cnt != '0) && (!valid_q || m_tready);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      fill_q  <= '0;
    end else begin
      if (accept) fill_q <= '0;
      if (hs) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      if (pull) begin
        data_q[lane_q*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
        if (lane_q == LW'(ELEMS_PER_BEAT - 1)) begin
          lane_q  <= '0;
          valid_q <= 1'b1;
          last_q  <= (fill_q == beats_q - 1'b1);
          fill_q  <= fill_q + 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  assign m_tdata  = data_q;
  assign m_tvalid = valid_q;
  assign m_tlast  = last_q;

`ifdef RESULT_READER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic [31:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < ELEMS_PER_BEAT; k++)
      beat_sum = beat_sum + 32'(data_q[k*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset)       sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (hs)     sum_q <= sum_q + beat_sum;
  end

  assign checksum       = sum_q;
  assign checksum_valid = done;
`endif

endmodule

// File: tb/tb_op_uram_result_reader.sv
// Randomized self-checking bench for op_uram_result_reader.
// Models the URAM array and the expected beat stream from the read order.
module tb_op_uram_result_reader;

  localparam int NUM_URAM   = 64;
  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 16;
  localparam int OUT_WIDTH  = 64;
  localparam int RD_LAT     = 3;
  localparam int FIFO_DEPTH = 8;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [ADDR_WIDTH:0]   cfg_num_addr;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] op_uram_addrb;
  logic [NUM_URAM-1:0]   op_uram_enb;
  logic [NUM_URAM-1:0]   op_uram_doutb_valid;
  logic [DATA_WIDTH-1:0] op_uram_doutb;
  logic [OUT_WIDTH-1:0]  m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [31:0]           checksum;
  logic                  checksum_valid;
`endif

  op_uram_result_reader #(
    .NUM_URAM   (NUM_URAM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .cfg_num_addr        (cfg_num_addr),
    .busy                (busy),
    .done                (done),
    .op_uram_addrb       (op_uram_addrb),
    .op_uram_enb         (op_uram_enb),
    .op_uram_doutb_valid (op_uram_doutb_valid),
    .op_uram_doutb       (op_uram_doutb),
    .m_tdata             (m_tdata),
    .m_tvalid            (m_tvalid),
    .m_tlast             (m_tlast),
    .m_tready            (m_tready)
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    .checksum            (checksum),
    .checksum_valid      (checksum_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int mode  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Contents of URAM u at address a for the current pattern
  function automatic logic [15:0] elem(input int a, input int u);
    logic [31:0] t;
    case (mode)
      0:       t = 32'((a * 64 + u) % 65536);
      1:       t = 32'(a * 40503 + u * 7919 + 12345);
      default: t = 32'hFFFF;
    endcase
    return t[15:0] ^ ((mode == 1) ? t[31:16] : 16'h0);
  endfunction

  // Beat j holds read indices 4j..4j+3, index i = a*64 + u
  function automatic logic [63:0] beat(input int j);
    logic [63:0] r;
    int i;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      i = 4 * j + k;
      r[16*k +: 16] = elem(i / 64, i % 64);
    end
    return r;
  endfunction

  function automatic int oh_idx(input logic [NUM_URAM-1:0] v);
    int r;
    r = 0;
    for (int k = 0; k < NUM_URAM; k++) if (v[k]) r = k;
    return r;
  endfunction

  // URAM array: data appears RD_LAT cycles after enable
  logic [15:0] s1, s2, s3;
  logic [NUM_URAM-1:0] h1, h2;
  assign op_uram_doutb = s3;

  always @(posedge clk) begin
    s1 <= (op_uram_enb != '0) ?
          elem(int'(op_uram_addrb), oh_idx(op_uram_enb)) : 16'hDEAD;
    s2 <= s1;
    s3 <= s2;
    if (reset) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      h1 <= op_uram_enb;
      h2 <= h1;
    end
  end

  task automatic idle_checks(input string tag);
    @(negedge clk);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_enb"}, op_uram_enb, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run(input int cfg, input int pct, input int abort_at,
                     input bit mid_start);
    int cyc, nb, lat, first_hs, last_hs, done_cyc;
    int issued, stall, busy_gap, total, limit;
    bit aborted;
    logic [31:0] sum;
    total = cfg * 16;
    limit = cfg * 64 * 20 + 200;
    cyc = 0; nb = 0; lat = -1; first_hs = -1; last_hs = -1;
    done_cyc = -1; issued = 0; stall = 0; busy_gap = 0;
    aborted = 0; sum = '0;
    @(posedge clk);
    #1 cfg_num_addr = (ADDR_WIDTH + 1)'(cfg);
    start = 1'b1;
    while (cyc < limit) begin
      @(posedge clk);
      cyc++;
      #1 start = mid_start && (cyc == 20);
      m_tready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (op_uram_enb != '0) begin
        issued++;
        chk("enb_onehot", $onehot(op_uram_enb), 1);
      end else if (busy && issued > 0 && issued < cfg * 64) begin
        stall = 1;
      end
      if (h2 != '0 || op_uram_doutb_valid != '0)
        chk("doutb_valid", op_uram_doutb_valid, h2);
      if (m_tvalid && lat < 0) lat = cyc - 1;
      if (m_tvalid && m_tready) begin
        if (mode == 0 && nb == 0)
          chk("beat0_const", m_tdata, 64'h0003_0002_0001_0000);
        chk("tdata", m_tdata, beat(nb));
        chk("tlast", m_tlast, (nb == total - 1));
        for (int k = 0; k < 4; k++) sum = sum + 32'(m_tdata[16*k +: 16]);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        nb++;
        if (abort_at >= 0 && nb == abort_at) begin
          reset = 1'b1;
          @(posedge clk);
          @(posedge clk);
          #1 reset = 1'b0;
          aborted = 1;
          break;
        end
      end
      if (done) begin
        done_cyc = cyc;
`ifdef RESULT_READER_CHECKSUM_EN
        chk("cksum_valid", checksum_valid, 1);
        chk("checksum", checksum, sum);
`endif
        break;
      end
      if (!busy) busy_gap++;
    end
    if (aborted) begin
      idle_checks("after_abort");
      return;
    end
    chk("done_seen", (done_cyc >= 0), 1);
    chk("busy_at_done", busy, 0);
    chk("beat_count", nb, total);
    if (cfg > 0) begin
      chk("done_after_last", done_cyc, last_hs + 1);
      chk("busy_gap", busy_gap, 0);
    end else begin
      chk("zero_done_cyc", done_cyc, 1);
      chk("zero_no_reads", issued, 0);
    end
    if (pct >= 100 && cfg > 0) begin
      chk("latency", lat, RD_LAT + 5);
      chk("no_gaps", last_hs - first_hs, (total - 1) * 4);
    end
    if (pct < 50 && cfg > 0) chk("credit_stall", stall, 1);
    if (cfg > 0) chk("reads_issued", issued, cfg * 64);
    for (int i = 0; i < 3; i++) idle_checks("post_done");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_num_addr = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_enb", op_uram_enb, 0);
    chk("rst_dv", op_uram_doutb_valid, 0);
    chk("rst_addrb", op_uram_addrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1 reset = 1'b0;

    mode = 0; run(1, 100, -1, 0);
    mode = 0; run(128, 100, -1, 0);
    mode = 1; run(4, 100, -1, 0);
    mode = 1; run(4, 30, -1, 1);
    run(0, 100, -1, 0);
    mode = 1; run(1, 100, 5, 0);
    mode = 1; run(1, 100, -1, 0);
    mode = 2; run(2, 100, -1, 0);
`ifdef RESULT_READER_CHECKSUM_EN
    chk("cksum_const", checksum, 32'h007F_FF80);
`endif
    for (int r = 0; r < 3; r++) begin
      mode = 1;
      run($urandom_range(6, 1), $urandom_range(100, 20), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
